aud_recorder_ch: RTL and testbench

Parametrised I2S capture engine, successor to the fixed 16-bit mono recorder in the audio path. It deserialises codec ADC data (WM8731, I2S mode, BCLK-domain) into DATA_W-bit words and presents each word with an SRAM address and a one-cycle write strobe. It supports start/pause/resume/stop control, a word count for the player, a full flag, and an optional stereo mode. It sits between the codec interface and the SRAM write arbiter, under control of the top-level FSM.

---
 rtl/aud_recorder_ch.sv | 171 +++++++++++++++++
 tb/tb_aud_recorder_ch.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/aud_recorder_ch.sv
// I2S ADC capture into DATA_W-bit words with SRAM address/strobe; stereo when AUD_REC_STEREO_EN is defined.
// Latency: o_wr rises DATA_W+1 BCLK edges after the opening LRCK edge, high for exactly one cycle.
// Backpressure: none; the write arbiter must accept every o_wr strobe.
module aud_recorder_ch #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 20
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_lrc,
    input  logic              i_data,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    output logic [ADDR_W-1:0] o_address,
    output logic [DATA_W-1:0] o_data,
    output logic              o_wr,
    output logic [ADDR_W:0]   o_len,
    output logic              o_full,
    output logic [1:0]        o_state
);

`ifdef AUD_REC_STEREO_EN
    localparam bit STEREO = 1'b1;
`else
    localparam bit STEREO = 1'b0;
`endif

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  LSB_CNT  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  DONE_CNT = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_CAPT  = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              lrc_q, lrc_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              full_q, full_d;
    // Set after a left word lands: the matching right slot may be captured.
    logic              rok_q, rok_d;

    logic              fall_edge, rise_edge, done, full_wrap, round_up;
    logic [ADDR_W-1:0] addr_upd;

    always_comb begin
        lrc_d     = i_lrc;
        state_d   = state_q;
        shift_d   = shift_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        wr_d      = 1'b0;
        addr_d    = addr_q;
        len_d     = len_q;
        full_d    = full_q;
        rok_d     = rok_q;
        fall_edge = lrc_q & ~i_lrc;
        rise_edge = ~lrc_q & i_lrc;
        done      = (state_q == S_CAPT) && (cnt_q == DONE_CNT);
        full_wrap = done && (addr_q == '1);
        addr_upd  = done ? addr_q + ADDR_ONE : addr_q;
        round_up  = STEREO && addr_upd[0];

        case (state_q)
            S_WAIT: begin
                if (fall_edge || (STEREO && rise_edge && rok_q)) begin
                    state_d = S_CAPT;
                    cnt_d   = '0;
                end
            end
            S_CAPT: begin
                if (done) begin
                    addr_d = addr_upd;
                    len_d  = len_q + LEN_ONE;
                    rok_d  = STEREO && !rok_q;
                    if (full_wrap) begin
                        full_d  = 1'b1;
                        rok_d   = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    shift_d = {shift_q[DATA_W-2:0], i_data};
                    if (cnt_q == LSB_CNT) begin
                        data_d = {shift_q[DATA_W-2:0], i_data};
                        wr_d   = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // A completing word keeps its address/len update; a partial word is dropped.
        if (i_stop) begin
            if (state_q != S_IDLE) begin
                state_d = S_IDLE;
                wr_d    = 1'b0;
                data_d  = data_q;
                rok_d   = 1'b0;
                addr_d  = addr_upd + ADDR_W'(round_up);
            end
        end else if (i_pause) begin
            if (state_q != S_IDLE) begin
                state_d = full_wrap ? S_IDLE : S_PAUSE;
                wr_d    = 1'b0;
                data_d  = data_q;
                rok_d   = 1'b0;
                addr_d  = addr_upd + ADDR_W'(round_up);
            end
        end else if (i_start) begin
            if (state_q == S_IDLE) begin
                state_d = S_WAIT;
                addr_d  = '0;
                len_d   = '0;
                full_d  = 1'b0;
                rok_d   = 1'b0;
            end else if (state_q == S_PAUSE) begin
                state_d = S_WAIT;
                rok_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            lrc_q   <= 1'b0;
            shift_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            full_q  <= 1'b0;
            rok_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lrc_q   <= lrc_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            full_q  <= full_d;
            rok_q   <= rok_d;
        end
    end

    assign o_address = addr_q;
    assign o_data    = data_q;
    assign o_wr      = wr_q;
    assign o_len     = len_q;
    assign o_full    = full_q;
    assign o_state   = state_q;

endmodule

// File: tb/tb_aud_recorder_ch.sv
// Randomised I2S frames with control pulses, checked against a slot-level recording model.
module tb_aud_recorder_ch;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;
    localparam int SL     = 20;
`ifdef AUD_REC_STEREO_EN
    localparam bit STEREO = 1'b1;
`else
    localparam bit STEREO = 1'b0;
`endif
    localparam int K_NONE = 0, K_START = 1, K_PAUSE = 2, K_STOP = 3;

    logic clk = 1'b0;
    logic rst, lrc, dat, start, pause, stop;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] odata;
    logic              wr;
    logic [ADDR_W:0]   len;
    logic              full;
    logic [1:0]        st;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int edge_cyc = 0;
    logic mon_prev = 1'b0;
    int got_q[$];
    int exp_q[$];

    int m_state, m_addr, m_len;
    bit m_full, m_rok;

    always #5 clk = ~clk;

    aud_recorder_ch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_lrc(lrc), .i_data(dat),
        .i_start(start), .i_pause(pause), .i_stop(stop),
        .o_address(addr), .o_data(odata), .o_wr(wr), .o_len(len),
        .o_full(full), .o_state(st)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            if (wr === 1'b1) begin
                check_val("wr_single", {31'd0, mon_prev}, 32'd0);
                check_val("wr_latency", cyc - edge_cyc, DATA_W + 1);
                got_q.push_back(int'({addr, odata}));
            end
            mon_prev = wr;
        end
    end

    // Recording model: works per control pulse and per LRCK slot.
    task automatic m_reset();
        m_state = 0; m_addr = 0; m_len = 0; m_full = 0; m_rok = 0;
    endtask

    task automatic m_ctl(input int kind);
        if (kind == K_STOP || kind == K_PAUSE) begin
            if (m_state != 0) begin
                m_state = (kind == K_STOP) ? 0 : 3;
                m_rok = 0;
                if (STEREO && (m_addr % 2 == 1)) m_addr = (m_addr + 1) % DEPTH;
            end
        end else if (kind == K_START) begin
            if (m_state == 0) begin
                m_state = 1; m_addr = 0; m_len = 0; m_full = 0; m_rok = 0;
            end else if (m_state == 3) begin
                m_state = 1; m_rok = 0;
            end
        end
    endtask

    task automatic m_slot(input bit left, input logic [15:0] w, input int cc, input int kind);
        bit opened, wrapped;
        opened  = (m_state == 1) && (left || (STEREO && m_rok));
        wrapped = 0;
        if (kind != K_NONE && cc <= DATA_W) begin
            m_ctl(kind);
        end else begin
            if (opened) begin
                exp_q.push_back((m_addr << 16) | int'(w));
                m_addr = (m_addr + 1) % DEPTH;
                m_len++;
                m_rok = left;
                if (m_addr == 0) begin
                    wrapped = 1; m_full = 1; m_state = 0; m_rok = 0;
                end
            end
            if (kind != K_NONE && !(cc == DATA_W + 1 && wrapped)) m_ctl(kind);
        end
    endtask

    task automatic drive(input bit l, input bit d, input int kind);
        @(negedge clk);
        lrc = l; dat = d;
        start = (kind == K_START);
        pause = (kind == K_PAUSE);
        stop  = (kind == K_STOP);
    endtask

    task automatic slot(input bit left, input logic [15:0] w, input int cc, input int kind);
        m_slot(left, w, cc, kind);
        for (int c = 0; c < SL; c++) begin
            bit d;
            d = (c >= 1 && c <= DATA_W) ? w[DATA_W - c] : 1'($urandom);
            drive(!left, d, (c == cc) ? kind : K_NONE);
            if (c == 0) edge_cyc = cyc;
        end
    endtask

    task automatic frame(input logic [15:0] lw, input logic [15:0] rw,
                         input int side, input int cc, input int kind);
        slot(1'b1, lw, (side == 0) ? cc : -1, (side == 0) ? kind : K_NONE);
        slot(1'b0, rw, (side == 1) ? cc : -1, (side == 1) ? kind : K_NONE);
    endtask

    task automatic ctl(input int kind);
        m_ctl(kind);
        drive(1'b1, 1'b0, kind);
        drive(1'b1, 1'b0, K_NONE);
    endtask

    task automatic check_status(input string tag);
        drive(1'b1, 1'b0, K_NONE);
        drive(1'b1, 1'b0, K_NONE);
        check_val({tag, ".state"}, {30'd0, st}, m_state);
        check_val({tag, ".addr"}, {29'd0, addr}, m_addr);
        check_val({tag, ".len"}, {28'd0, len}, m_len);
        check_val({tag, ".full"}, {31'd0, full}, {31'd0, m_full});
        check_val({tag, ".nwr"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check_val({tag, ".wr"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, ".state"}, {30'd0, st}, 0);
        check_val({tag, ".addr"}, {29'd0, addr}, 0);
        check_val({tag, ".data"}, {16'd0, odata}, 0);
        check_val({tag, ".wr"}, {31'd0, wr}, 0);
        check_val({tag, ".len"}, {28'd0, len}, 0);
        check_val({tag, ".full"}, {31'd0, full}, 0);
    endtask

    initial begin
        rst = 1'b1; lrc = 1'b1; dat = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
        m_reset();
        drive(1'b1, 1'b0, K_NONE);
        drive(1'b1, 1'b0, K_NONE);
        check_reset("reset");
        rst = 1'b0;
        drive(1'b1, 1'b0, K_NONE);

        // Reset in the middle of a capture.
        ctl(K_START);
        for (int c = 0; c < 9; c++) drive(1'b0, 1'($urandom), K_NONE);
        rst = 1'b1;
        drive(1'b0, 1'b0, K_NONE);
        drive(1'b0, 1'b0, K_NONE);
        check_reset("rst_mid");
        rst = 1'b0;
        m_reset();
        drive(1'b1, 1'b0, K_NONE);
        drive(1'b1, 1'b0, K_NONE);
        check_val("rst_mid.nwr", got_q.size(), 0);
        got_q.delete();

        ctl(K_START);
        frame(16'hF2CF, 16'($urandom), 0, -1, K_NONE);
        frame(16'hF64F, 16'($urandom), 0, -1, K_NONE);
        frame(16'h83C1, 16'($urandom), 0, -1, K_NONE);
        check_status("mono");

        ctl(K_STOP);
        ctl(K_START);
        frame(16'h1234, 16'h5678, 0, -1, K_NONE);
        frame(16'h9C58, 16'h0F0F, 0, 5, K_PAUSE);
        check_status("pause");
        ctl(K_START);
        frame(16'hBEEF, 16'hCAFE, 0, -1, K_NONE);
        frame(16'h0DD0, 16'h7117, 0, DATA_W + 1, K_PAUSE);
        check_status("resume");

        ctl(K_STOP);
        ctl(K_START);
        frame(16'hA5A5, 16'h5A5A, 0, -1, K_NONE);
        frame(16'h3C3C, 16'hC3C3, 0, 8, K_STOP);
        check_status("stop");
        ctl(K_START);
        check_status("fresh");

        for (int f = 0; f < 10; f++) frame(16'($urandom), 16'($urandom), 0, -1, K_NONE);
        check_status("full");

        ctl(K_START);
        frame(16'h6A4C, 16'hF2CF, 0, -1, K_NONE);
        frame(16'h1111, 16'h2222, 1, 5, K_STOP);
        check_status("pair");

        for (int f = 0; f < 48; f++) begin
            int kind, side, cc;
            kind = K_NONE; side = 0; cc = -1;
            if ($urandom_range(0, 2) == 0) begin
                kind = $urandom_range(1, 3);
                side = $urandom_range(0, 1);
                cc   = $urandom_range(1, SL - 1);
                if (cc == DATA_W + 1 && kind == K_START) cc = DATA_W + 2;
            end
            frame(16'($urandom), 16'($urandom), side, cc, kind);
            if (f % 8 == 7) check_status("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
